// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
//   Steps a single ALU operation across a shared bus: operand A is driven and
//   loaded, then operand B, then the ALU result is enabled and captured. The
//   result is held for the consumer until it is taken. Illegal opcodes skip
//   the bus sequence and go straight to the result stage with an error flag.
//
// Ports
//   clk, reset             clock; synchronous active-high reset
//   instr_valid/ready      request handshake (accepted in IDLE only)
//   instr_op/a/b           opcode and operands, latched on acceptance
//   bus_out, bus_drive     shared ALU bus value and its drive enable
//   alu_en[2:0]            [0] load A, [1] load B, [2] ALU result enable
//   alu_func               function select to the ALU
//   alu_result             ALU result bus (valid while alu_en[2] = 1)
//   res_valid/ready        result handshake
//   res_data, res_err      captured result and illegal-opcode flag
//   op_count               legal operations completed, modulo 256
//   dbg_state              current FSM state encoding
//
// Handshakes: a transfer happens on a rising edge where valid & ready are
// both 1. The producer holds its payload stable while valid is high and
// ready is low; ready may depend on state but never on valid.
// ---------------------------------------------------------------------------
module alu_sequencer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        instr_op,
    input  logic [DATA_W-1:0] instr_a,
    input  logic [DATA_W-1:0] instr_b,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_drive,
    output logic [2:0]        alu_en,
    output logic [3:0]        alu_func,
    input  logic [DATA_W-1:0] alu_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_err,
    output logic [7:0]        op_count,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_op;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_res_data;
    logic              r_res_err;
    logic [7:0]        r_op_count;

    logic              w_accept;
    logic              w_legal;
    logic              w_hold_exit;

    // Legal codes are 0000-0011 and 1000-1011, i.e. exactly those with bit 2 clear.
    assign w_legal     = ~instr_op[2];
    assign w_accept    = instr_valid & (r_state == ST_IDLE);
    assign w_hold_exit = res_ready & (r_state == ST_HOLD);

    always_comb begin
        w_next      = r_state;
        instr_ready = 1'b0;
        bus_out     = '0;
        bus_drive   = 1'b0;
        alu_en      = 3'b000;
        alu_func    = r_op;
        res_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                alu_func    = 4'b0000;
                if (instr_valid) begin
                    w_next = w_legal ? ST_LOAD_A : ST_HOLD;
                end
            end
            ST_LOAD_A: begin
                bus_drive = 1'b1;
                bus_out   = r_a;
                alu_en    = 3'b001;
                w_next    = ST_LOAD_B;
            end
            ST_LOAD_B: begin
                bus_drive = 1'b1;
                bus_out   = r_b;
                alu_en    = 3'b010;
                w_next    = ST_EXEC;
            end
            ST_EXEC: begin
                // Bus is released here so the ALU can drive its result.
                alu_en = 3'b100;
                w_next = ST_HOLD;
            end
            ST_HOLD: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_op       <= 4'b0000;
            r_a        <= '0;
            r_b        <= '0;
            r_res_data <= '0;
            r_res_err  <= 1'b0;
            r_op_count <= 8'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op <= instr_op;
                r_a  <= instr_a;
                r_b  <= instr_b;
                if (!w_legal) begin
                    r_res_data <= '0;
                    r_res_err  <= 1'b1;
                end
            end
            if (r_state == ST_EXEC) begin
                r_res_data <= alu_result;
                r_res_err  <= 1'b0;
            end
            // r_res_err still describes the result being handed over.
            if (w_hold_exit && !r_res_err) begin
                r_op_count <= r_op_count + 8'd1;
            end
        end
    end

    assign res_data  = r_res_data;
    assign res_err   = r_res_err;
    assign op_count  = r_op_count;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
//   Bench for alu_sequencer with a small behavioural ALU on the shared bus.
//   A table of legal and illegal operations is run end to end, followed by
//   hand-written reset and counter-wrap sequences.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    always #5 clk = ~clk;

    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] instr_op;
    logic [7:0] instr_a;
    logic [7:0] instr_b;
    logic [7:0] bus_out;
    logic       bus_drive;
    logic [2:0] alu_en;
    logic [3:0] alu_func;
    logic [7:0] alu_result;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_err;
    logic [7:0] op_count;
    logic [2:0] dbg_state;

    alu_sequencer #(.DATA_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_a     (instr_a),
        .instr_b     (instr_b),
        .bus_out     (bus_out),
        .bus_drive   (bus_drive),
        .alu_en      (alu_en),
        .alu_func    (alu_func),
        .alu_result  (alu_result),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_err     (res_err),
        .op_count    (op_count),
        .dbg_state   (dbg_state)
    );

    // ---------------- behavioural ALU ----------------
    logic [7:0] m_a = 8'h00;
    logic [7:0] m_b = 8'h00;

    function automatic logic [7:0] alu_f(input logic [3:0] f, input logic [7:0] x, input logic [7:0] y);
        case (f)
            4'b0000: return x & y;
            4'b0001: return x + y;
            4'b0010: return x - y;
            4'b0011: return x | y;
            4'b1000: return ~x;
            4'b1001: return x << 1;
            4'b1010: return x >> 1;
            4'b1011: return x ^ y;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        if (alu_en[0]) m_a <= bus_out;
        if (alu_en[1]) m_b <= bus_out;
    end

    // 8'hEE when not enabled, so a capture in the wrong cycle shows up.
    assign alu_result = alu_en[2] ? alu_f(alu_func, m_a, m_b) : 8'hEE;

    // ---------------- bus contention monitor ----------------
    int contention = 0;
    always @(negedge clk) begin
        if (bus_drive && alu_en[2]) contention++;
    end

    // ---------------- scoreboard ----------------
    int         n_pass  = 0;
    int         n_total = 0;
    logic [7:0] exp_count;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_count = 8'd0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"},       dbg_state,   3'd0);
        check({tag, "_instr_ready"}, instr_ready, 1);
        check({tag, "_res_valid"},   res_valid,   0);
        check({tag, "_res_data"},    res_data,    8'h00);
        check({tag, "_res_err"},     res_err,     0);
        check({tag, "_op_count"},    op_count,    8'd0);
        check({tag, "_bus_drive"},   bus_drive,   0);
        check({tag, "_bus_out"},     bus_out,     8'h00);
        check({tag, "_alu_en"},      alu_en,      3'b000);
        check({tag, "_alu_func"},    alu_func,    4'b0000);
    endtask

    // One full request: accept, sequence, hold for 'hold' cycles, release.
    task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic exp_e, input int hold);
        int          t;
        int          guard;
        int          exp_lat;
        logic [8:0]  en_seq;
        logic [23:0] bus_seq;
        logic [11:0] fn_seq;
        logic [7:0]  exp_d;
        bit          ok;

        exp_d = exp_q.pop_front();
        guard = 0;
        while (!instr_ready && guard < 20) begin
            tick();
            guard++;
        end
        check("ready_before_accept", instr_ready, 1);

        instr_valid = 1'b1;
        instr_op    = op;
        instr_a     = a;
        instr_b     = b;
        tick();
        // Scramble inputs: the design must use the latched copies.
        instr_valid = 1'b0;
        instr_op    = ~op;
        instr_a     = ~a;
        instr_b     = b + 8'h55;

        t       = 1;
        en_seq  = '0;
        bus_seq = '0;
        fn_seq  = '0;
        while (!res_valid && t < 10) begin
            en_seq  = {en_seq[5:0], alu_en};
            bus_seq = {bus_seq[15:0], bus_out};
            fn_seq  = {fn_seq[7:0], alu_func};
            tick();
            t++;
        end
        exp_lat = exp_e ? 1 : 4;
        check("latency", t, exp_lat);
        if (!exp_e) begin
            check("alu_en_seq",   en_seq,  9'b001_010_100);
            check("bus_seq",      bus_seq, {a, b, 8'h00});
            check("alu_func_seq", fn_seq,  {op, op, op});
        end else begin
            check("illegal_alu_en",    alu_en,    3'b000);
            check("illegal_bus_drive", bus_drive, 0);
        end
        check("res_data",          res_data,    exp_d);
        check("res_err",           res_err,     exp_e);
        check("hold_alu_func",     alu_func,    op);
        check("hold_instr_ready",  instr_ready, 0);
        check("hold_op_count",     op_count,    exp_count);

        ok = 1'b1;
        repeat (hold) begin
            tick();
            if (!res_valid || res_data !== exp_d || res_err !== exp_e || instr_ready) ok = 1'b0;
        end
        check("hold_stable", ok, 1);

        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        if (!exp_e) exp_count = exp_count + 8'd1;
        check("exit_res_valid",   res_valid,   0);
        check("exit_instr_ready", instr_ready, 1);
        check("exit_op_count",    op_count,    exp_count);
        check("exit_alu_func",    alu_func,    4'b0000);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_d;
        logic       exp_e;
        int         hold;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  guard;
        bit  saw_valid;

        vecs[0]  = '{op: 4'b0001, a: 8'h05, b: 8'h03, exp_d: 8'h08, exp_e: 1'b0, hold: 0};
        vecs[1]  = '{op: 4'b0010, a: 8'h00, b: 8'h01, exp_d: 8'hFF, exp_e: 1'b0, hold: 5};
        vecs[2]  = '{op: 4'b0100, a: 8'h12, b: 8'h34, exp_d: 8'h00, exp_e: 1'b1, hold: 2};
        vecs[3]  = '{op: 4'b0000, a: 8'hF0, b: 8'h3C, exp_d: 8'h30, exp_e: 1'b0, hold: 1};
        vecs[4]  = '{op: 4'b0011, a: 8'hF0, b: 8'h0F, exp_d: 8'hFF, exp_e: 1'b0, hold: 0};
        vecs[5]  = '{op: 4'b1000, a: 8'h5A, b: 8'h77, exp_d: 8'hA5, exp_e: 1'b0, hold: 0};
        vecs[6]  = '{op: 4'b1111, a: 8'hFF, b: 8'hFF, exp_d: 8'h00, exp_e: 1'b1, hold: 0};
        vecs[7]  = '{op: 4'b1001, a: 8'h81, b: 8'h00, exp_d: 8'h02, exp_e: 1'b0, hold: 3};
        vecs[8]  = '{op: 4'b1010, a: 8'h81, b: 8'h00, exp_d: 8'h40, exp_e: 1'b0, hold: 0};
        vecs[9]  = '{op: 4'b0111, a: 8'h01, b: 8'h02, exp_d: 8'h00, exp_e: 1'b1, hold: 0};
        vecs[10] = '{op: 4'b1011, a: 8'hAA, b: 8'h0F, exp_d: 8'hA5, exp_e: 1'b0, hold: 0};

        instr_valid = 1'b0;
        instr_op    = 4'b0000;
        instr_a     = 8'h00;
        instr_b     = 8'h00;
        res_ready   = 1'b0;
        exp_count   = 8'd0;

        apply_reset();
        check_reset_values("por");

        // Table: legal and illegal operations.
        for (int i = 0; i < 11; i++) begin
            exp_q.push_back(vecs[i].exp_d);
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_e, vecs[i].hold);
        end

        // Reset during LOAD_B aborts the operation.
        instr_valid = 1'b1;
        instr_op    = 4'b0001;
        instr_a     = 8'h11;
        instr_b     = 8'h22;
        tick();
        instr_valid = 1'b0;
        tick();
        check("midop_in_load_b", bus_out, 8'h22);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_count = 8'd0;
        check_reset_values("midop");
        saw_valid = 1'b0;
        repeat (6) begin
            tick();
            if (res_valid) saw_valid = 1'b1;
        end
        check("midop_no_result", saw_valid, 0);

        // Acceptance in the same cycle as reset is discarded.
        instr_valid = 1'b1;
        instr_op    = 4'b0001;
        reset       = 1'b1;
        tick();
        reset       = 1'b0;
        instr_valid = 1'b0;
        check("accept_vs_reset_state", dbg_state, 3'd0);
        tick();
        check("accept_vs_reset_idle", bus_drive, 0);

        // HOLD exit in the same cycle as reset is discarded (no count).
        instr_valid = 1'b1;
        instr_op    = 4'b0001;
        instr_a     = 8'h01;
        instr_b     = 8'h01;
        tick();
        instr_valid = 1'b0;
        guard = 0;
        while (!res_valid && guard < 10) begin
            tick();
            guard++;
        end
        check("hold_vs_reset_reached", res_valid, 1);
        res_ready = 1'b1;
        reset     = 1'b1;
        tick();
        reset     = 1'b0;
        res_ready = 1'b0;
        check_reset_values("hold_vs_reset");

        // 256 back-to-back XOR ops wrap the counter.
        apply_reset();
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back(8'(i) ^ 8'h3C);
            run_op(4'b1011, 8'(i), 8'h3C, 1'b0, 0);
        end
        check("wrap_op_count_zero", op_count, 8'd0);

        check("no_bus_contention", contention, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have one parameter: DATA_W, default 8, operand/result width; only 8 is supported, to match the ALU bus.
REQ-002 clk  input  1  the single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 instr_valid  input  1  an operation request is present.
REQ-005 instr_ready  output  1  the block accepts a request this cycle.
REQ-006 instr_op  input  4  ALU function code.
REQ-007 instr_a / instr_b  input  8 each  operand A / operand B.
REQ-008 bus_out  output  8  value driven onto the shared ALU bus.
REQ-009 bus_drive  output  1  bus_out is valid on the bus (tristate enable).
REQ-010 alu_en  output  3  [0] load A, [1] load B, [2] ALU result output enable.
REQ-011 alu_func  output  4  function select to the ALU.
REQ-012 alu_result  input  8  ALU result bus, valid while alu_en[2]=1.
REQ-013 res_valid  output  1  res_data and res_err are valid.
REQ-014 res_ready  input  1  the consumer takes the result.
REQ-015 res_data  output  8  captured result.
REQ-016 res_err  output  1  the request had an illegal opcode.
REQ-017 op_count  output  8  number of completed legal operations, modulo 256.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD_A, LOAD_B, EXEC, HOLD.
REQ-019 instr_ready SHALL be 1 only in IDLE; a request is accepted when instr_valid & instr_ready on a rising edge.
REQ-020 On acceptance, instr_op, instr_a and instr_b SHALL be latched internally; later input changes have no effect until the next acceptance.
REQ-021 Legal opcodes: 0000-0011 and 1000-1011; every other code is illegal.
REQ-022 Legal acceptance: IDLE->LOAD_A; LOAD_A->LOAD_B; LOAD_B->EXEC; EXEC->HOLD, each unconditional after one cycle.
REQ-023 LOAD_A: bus_drive=1, bus_out=A, alu_en=001.
REQ-024 LOAD_B: bus_drive=1, bus_out=B, alu_en=010.
REQ-025 EXEC: bus_drive=0, alu_en=100, alu_func=latched op; alu_result is captured into res_data and res_err=0 at the end of EXEC.
REQ-026 Illegal acceptance: IDLE->HOLD directly, with res_data=0 and res_err=1; no bus or ALU enable is asserted.
REQ-027 HOLD: res_valid=1; res_data and res_err are held stable until res_valid & res_ready, then the FSM goes to IDLE.
REQ-028 A request is not accepted in the same cycle HOLD exits; the earliest next acceptance is the following IDLE cycle.
REQ-029 Latency, legal op: accept edge at cycle 0 -> res_valid=1 from cycle 4 (cycles 1-3 are LOAD_A, LOAD_B, EXEC).
REQ-030 Latency, illegal op: res_valid=1 from cycle 1.
REQ-031 Outside the states named in REQ-023-REQ-025: bus_drive=0, alu_en=000, bus_out=0.
REQ-032 alu_func SHALL equal the latched op in all states after acceptance, and 0000 in IDLE.
REQ-033 bus_drive and alu_en[2] SHALL never both be 1 (no bus contention).
REQ-034 op_count SHALL increment by 1 on each HOLD exit with res_err=0, wrapping 255->0; illegal ops do not count.
REQ-035 res_valid SHALL be 0 in all states except HOLD.

Reset
REQ-036 reset SHALL return the FSM to IDLE from any state on the next edge, aborting any in-flight operation without producing a result.
REQ-037 Reset values: res_valid=0, res_data=0, res_err=0, op_count=0, bus_drive=0, bus_out=0, alu_en=000, alu_func=0000, latched operands=0; instr_ready=1 in the first cycle after reset is released.
REQ-038 reset SHALL take priority over the handshake: an acceptance or HOLD exit in the same cycle as reset is discarded.

Verification
REQ-039 Add: op=0001, A=0x05, B=0x03 with a model ALU -> alu_en sequence 001,010,100; res_data=0x08 at cycle 4; op_count=1.
REQ-040 Sub wrap and backpressure: op=0010, A=0x00, B=0x01, res_ready low for 5 cycles -> res_data=0xFF stable throughout; instr_ready=0 until the cycle after the HOLD exit.
REQ-041 Illegal op: op=0100 -> res_valid at cycle 1, res_err=1, res_data=0; alu_en stays 000; op_count unchanged.
REQ-042 Reset mid-op: assert reset during LOAD_B -> IDLE next cycle, all outputs at reset values, no res_valid.
REQ-043 Counter wrap: 256 back-to-back XOR ops (1011) -> op_count returns to 0; bus_drive & alu_en[2] is never 1 on any cycle.
